// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the run controller.
// State/verdict encodings match the published status field.
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        RUN        = 2'd1,
        DONE       = 2'd2
    } run_state_e;

    typedef enum logic [1:0] {
        RUNNING = 2'd0,
        PASS    = 2'd1,
        FAIL    = 2'd2,
        TIMEOUT = 2'd3
    } run_status_e;

    // jal x0,0 : the conventional "halt here forever" idiom
    localparam logic [31:0] JAL_SELF = 32'h0000_006F;

endpackage

// File: rtl/cpu_loop_det.sv
// Self-loop halt detector: pulses halt on the cycle the LOOP_CYCLES-th consecutive jal-self is seen.
// Latency: combinational halt from registered history; no backpressure, observes only while run=1.
module cpu_loop_det
    import cpu_run_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int LOOP_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic [XLEN-1:0] pc,
    input  logic [31:0]     instr,
    output logic            halt
);

    localparam int CW = (LOOP_CYCLES > 2) ? $clog2(LOOP_CYCLES) : 1;

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] prev_pc_q, prev_pc_d;
    logic            prev_vld_q, prev_vld_d;
    logic            same;

    always_comb begin
        same       = run && prev_vld_q && (instr == JAL_SELF) && (pc == prev_pc_q);
        cnt_d      = same ? cnt_q + 1'b1 : '0;
        prev_pc_d  = pc;
        prev_vld_d = run;
        // Fires when the count is about to reach LOOP_CYCLES-1
        halt       = same && (cnt_q == CW'(LOOP_CYCLES - 2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            prev_pc_q  <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            prev_pc_q  <= prev_pc_d;
            prev_vld_q <= prev_vld_d;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: sequences core reset, counts run cycles, latches PASS/FAIL/TIMEOUT verdict.
// Optional self-loop halt detection under CPU_RUN_CTRL_LOOP_DET_EN; all outputs registered.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter int              RST_CYCLES     = 2,
    parameter int              TIMEOUT_CYCLES = 1000,
    parameter int              CNT_W          = 32,
    parameter logic [XLEN-1:0] TOHOST_ADDR    = 'h0000_0FFC,
    parameter int              LOOP_CYCLES    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic [XLEN-1:0]  pc,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  aluresult,
    input  logic [XLEN-1:0]  writedata,
    input  logic             memwrite,
    output logic             cpu_rst_n,
    output logic             done,
    output logic [1:0]       status,
    output logic [XLEN-2:0]  fail_code,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    run_state_e  state_q, state_d;
    run_status_e status_q, status_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [XLEN-2:0]   fail_code_q, fail_code_d;
    logic              done_q, done_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              tohost;
    logic              loop_halt;

`ifdef CPU_RUN_CTRL_LOOP_DET_EN
    cpu_loop_det #(
        .XLEN        (XLEN),
        .LOOP_CYCLES (LOOP_CYCLES)
    ) u_loop_det (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (state_q == RUN),
        .pc    (pc),
        .instr (instr),
        .halt  (loop_halt)
    );
`else
    logic unused_loop_inputs;
    assign unused_loop_inputs = ^{pc, instr};
    assign loop_halt          = 1'b0;
`endif

    assign tohost = memwrite && (aluresult == TOHOST_ADDR);

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        hold_d      = hold_q;
        cycle_cnt_d = cycle_cnt_q;
        fail_code_d = fail_code_q;
        done_d      = done_q;
        cpu_rst_n_d = cpu_rst_n_q;

        case (state_q)
            RESET_HOLD: begin
                cpu_rst_n_d = 1'b0;
                if (hold_q == HOLD_W'(RST_CYCLES - 1)) begin
                    state_d     = RUN;
                    hold_d      = '0;
                    cpu_rst_n_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RUN: begin
                if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 1'b1;
                if (tohost) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    if (writedata == XLEN'(1)) begin
                        status_d = PASS;
                    end else begin
                        status_d    = FAIL;
                        fail_code_d = writedata[XLEN-1:1];
                    end
                end else if (loop_halt) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    status_d = PASS;
                end else if (cycle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    status_d = TIMEOUT;
                end
            end
            default: ;
        endcase

        // Restart wins over any event sampled in the same cycle
        if (restart) begin
            state_d     = RESET_HOLD;
            status_d    = RUNNING;
            hold_d      = '0;
            cycle_cnt_d = '0;
            fail_code_d = '0;
            done_d      = 1'b0;
            cpu_rst_n_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_HOLD;
            status_q    <= RUNNING;
            hold_q      <= '0;
            cycle_cnt_q <= '0;
            fail_code_q <= '0;
            done_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            hold_q      <= hold_d;
            cycle_cnt_q <= cycle_cnt_d;
            fail_code_q <= fail_code_d;
            done_q      <= done_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    assign cpu_rst_n = cpu_rst_n_q;
    assign done      = done_q;
    assign status    = status_q;
    assign fail_code = fail_code_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: expected verdicts are queued with each stimulus and checked at done.
module tb_cpu_run_ctrl;
    import cpu_run_ctrl_pkg::*;

    localparam logic [31:0] TOHOST = 32'h0000_0FFC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        restart = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic [31:0] aluresult = '0;
    logic [31:0] writedata = '0;
    logic        memwrite = 1'b0;
    logic        cpu_rst_n;
    logic        done;
    logic [1:0]  status;
    logic [30:0] fail_code;
    logic [31:0] cycle_cnt;

    typedef struct packed {
        logic [1:0]  st;
        logic [30:0] fc;
        logic [31:0] cc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err = 0;

    cpu_run_ctrl #(
        .XLEN           (32),
        .RST_CYCLES     (2),
        .TIMEOUT_CYCLES (20),
        .CNT_W          (32),
        .TOHOST_ADDR    (32'h0000_0FFC),
        .LOOP_CYCLES    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (restart),
        .pc        (pc),
        .instr     (instr),
        .aluresult (aluresult),
        .writedata (writedata),
        .memwrite  (memwrite),
        .cpu_rst_n (cpu_rst_n),
        .done      (done),
        .status    (status),
        .fail_code (fail_code),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        memwrite  = 1'b1;
        aluresult = addr;
        writedata = data;
        @(negedge clk);
        memwrite  = 1'b0;
        aluresult = '0;
        writedata = '0;
    endtask

    task automatic check_done(input string tag);
        exp_t e;
        int   i = 0;
        while (!done && i < 64) begin
            @(negedge clk);
            i++;
        end
        chk({tag, ".done"}, done, 1'b1);
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 1'b1, 1'b0);
        end else begin
            e = sb.pop_front();
            chk({tag, ".status"}, status, e.st);
            chk({tag, ".fail_code"}, fail_code, e.fc);
            chk({tag, ".cycle_cnt"}, cycle_cnt, e.cc);
        end
    endtask

    // Leaves the bench at the negedge of RUN cycle 1
    task automatic do_restart(input string tag);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk({tag, ".rs_done"}, done, 1'b0);
        chk({tag, ".rs_cpu_rst_n"}, cpu_rst_n, 1'b0);
        chk({tag, ".rs_cycle_cnt"}, cycle_cnt, 32'd0);
        chk({tag, ".rs_status"}, status, 2'd0);
        repeat (2) @(negedge clk);
        chk({tag, ".rs_release"}, cpu_rst_n, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst.cpu_rst_n", cpu_rst_n, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.status", status, 2'd0);
        chk("rst.fail_code", fail_code, 31'd0);
        chk("rst.cycle_cnt", cycle_cnt, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel.edge1", cpu_rst_n, 1'b0);
        @(negedge clk);
        chk("rel.edge2", cpu_rst_n, 1'b1);
        chk("rel.status", status, 2'd0);
        chk("rel.done", done, 1'b0);
        chk("rel.cycle_cnt", cycle_cnt, 32'd0);

        // PASS at RUN cycle 10
        repeat (9) @(negedge clk);
        chk("pass10.pre_cnt", cycle_cnt, 32'd9);
        sb.push_back('{st: 2'd1, fc: 31'd0, cc: 32'd10});
        store(TOHOST, 32'd1);
        check_done("pass10");

        // FAIL with code, then a later store is ignored
        do_restart("fail");
        repeat (2) @(negedge clk);
        sb.push_back('{st: 2'd2, fc: 31'd3, cc: 32'd3});
        store(TOHOST, 32'h0000_0007);
        check_done("fail");
        store(TOHOST, 32'd1);
        repeat (2) @(negedge clk);
        chk("frozen.status", status, 2'd2);
        chk("frozen.fail_code", fail_code, 31'd3);
        chk("frozen.cycle_cnt", cycle_cnt, 32'd3);

        // Timeout; non-tohost store and unstrobed tohost address must not end the run
        do_restart("tmo");
        repeat (4) @(negedge clk);
        store(32'h0000_0FF8, 32'd1);
        aluresult = TOHOST;
        writedata = 32'd1;
        @(negedge clk);
        aluresult = '0;
        writedata = '0;
        chk("tmo.running", done, 1'b0);
        sb.push_back('{st: 2'd3, fc: 31'd0, cc: 32'd20});
        check_done("tmo");

        // Tohost on the timeout cycle takes priority
        do_restart("tie");
        repeat (19) @(negedge clk);
        sb.push_back('{st: 2'd1, fc: 31'd0, cc: 32'd20});
        store(TOHOST, 32'd1);
        check_done("tie");

        // Self-loop at 0x40 for 4 cycles
        do_restart("loop");
        pc    = 32'h40;
        instr = JAL_SELF;
        repeat (4) @(negedge clk);
        pc    = 32'h44;
        instr = 32'h0000_0013;
`ifdef CPU_RUN_CTRL_LOOP_DET_EN
        sb.push_back('{st: 2'd1, fc: 31'd0, cc: 32'd4});
`else
        sb.push_back('{st: 2'd3, fc: 31'd0, cc: 32'd20});
`endif
        check_done("loop");
        pc    = '0;
        instr = '0;

        // Restart overrides a same-cycle tohost event
        do_restart("ovr");
        repeat (2) @(negedge clk);
        memwrite  = 1'b1;
        aluresult = TOHOST;
        writedata = 32'd1;
        restart   = 1'b1;
        @(negedge clk);
        memwrite  = 1'b0;
        restart   = 1'b0;
        chk("ovr.done", done, 1'b0);
        chk("ovr.status", status, 2'd0);
        chk("ovr.cpu_rst_n", cpu_rst_n, 1'b0);
        repeat (2) @(negedge clk);
        chk("ovr.release", cpu_rst_n, 1'b1);

        // Asynchronous reset mid-RUN
        repeat (5) @(negedge clk);
        chk("mid.cycle_cnt", cycle_cnt, 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.cpu_rst_n", cpu_rst_n, 1'b0);
        chk("mid.cycle_cnt0", cycle_cnt, 32'd0);
        chk("mid.done", done, 1'b0);
        chk("mid.status", status, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid.hold", cpu_rst_n, 1'b0);
        @(negedge clk);
        chk("mid.release", cpu_rst_n, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Synthesisable run controller for the RISC-V core, placed beside `top` and wired to its architectural observation signals. It sequences the core's reset release and counts run cycles. It stops the run on a tohost store, a self-loop halt or a timeout, and publishes a latched pass/fail/timeout verdict. This makes a program's outcome visible to benches and to FPGA status pins without a fixed simulation length.

## Interface
- `XLEN`, 32, datapath width of observed signals
- `RST_CYCLES`, 2, cycles `cpu_rst_n` is held low after entry to RESET_HOLD (≥1)
- `TIMEOUT_CYCLES`, 1000, run cycles before TIMEOUT verdict (≥1, < 2^CNT_W)
- `CNT_W`, 32, cycle counter width
- `TOHOST_ADDR`, 32'h0000_0FFC, store address that ends the run
- `LOOP_CYCLES`, 4, consecutive self-loop cycles that count as halt (≥2)
- `clk` in 1 — single clock
- `rst_n` in 1 — asynchronous, active-low reset
- `restart` in 1 — synchronous pulse; restarts the run sequence
- `pc` in XLEN — core program counter
- `instr` in 32 — instruction at `pc`
- `aluresult` in XLEN — store address when `memwrite`=1
- `writedata` in XLEN — store data
- `memwrite` in 1 — data-memory write strobe
- `cpu_rst_n` out 1 — registered active-low reset to the core
- `done` out 1 — run finished, verdict valid
- `status` out 2 — 0 RUNNING, 1 PASS, 2 FAIL, 3 TIMEOUT
- `fail_code` out XLEN-1 — `writedata[XLEN-1:1]` of a failing tohost store, else 0
- `cycle_cnt` out CNT_W — RUN cycles elapsed, frozen in DONE

## Operation
- FSM states: RESET_HOLD, RUN, DONE.
- RESET_HOLD:
  - `cpu_rst_n`=0; hold counter counts 0..RST_CYCLES-1.
  - Leaves to RUN on the cycle the counter reaches RST_CYCLES-1.
  - Entry clears `cycle_cnt`, `fail_code`, `status`, `done` and the loop counter.
- RUN:
  - `cpu_rst_n`=1; `cycle_cnt` increments every cycle, saturating at all-ones.
  - Event priority, highest first:
    1. Tohost: `memwrite`=1 and `aluresult`==TOHOST_ADDR. `writedata`==1 → PASS. Any other value → FAIL, `fail_code`=`writedata[XLEN-1:1]`.
    2. Loop halt (macro only): → PASS.
    3. Timeout: `cycle_cnt`==TIMEOUT_CYCLES-1 → TIMEOUT.
  - Any event → DONE.
- DONE:
  - `cpu_rst_n` stays 1; `done`=1; `status`, `fail_code` and `cycle_cnt` are frozen.
  - Further stores are ignored.
- `restart`=1 in any state → RESET_HOLD on the next edge. It overrides a same-cycle event.
- Observation inputs are ignored outside RUN.

## Timing
- Reset values: `cpu_rst_n`=0, `done`=0, `status`=0, `fail_code`=0, `cycle_cnt`=0, state RESET_HOLD.
- `cpu_rst_n` rises on the RST_CYCLES-th rising edge after `rst_n` deasserts.
- All outputs are registered. `done`/`status` assert one edge after the cycle the event is sampled.
- `cycle_cnt` in DONE equals the number of RUN cycles, including the event cycle.
- `rst_n` asserted mid-run → immediate RESET_HOLD with all outputs at reset values. No verdict is retained.

## Configuration
- `CPU_RUN_CTRL_LOOP_DET_EN` defined:
  - Loop counter increments while `instr`==32'h0000006F (`jal x0,0`) and `pc` equals the previous cycle's `pc`. Any other cycle clears it.
  - Reaching LOOP_CYCLES-1 raises the loop-halt event.
- Undefined: the loop logic is absent; a self-looping program ends in TIMEOUT.

## Structure
- Package `cpu_run_ctrl_pkg`:
  - `run_state_e` (RESET_HOLD/RUN/DONE)
  - `run_status_e` (RUNNING/PASS/FAIL/TIMEOUT)
  - constant `JAL_SELF` = 32'h0000006F
- Sub-module `cpu_loop_det`: `pc`/`instr` in, `halt` pulse out, LOOP_CYCLES parameter. Instantiated only under the macro.

## Test plan
- Reset release with RST_CYCLES=2 → `cpu_rst_n`=0 for 2 edges after `rst_n` rises, then 1. `status`=0, `done`=0.
- At cycle 10 of RUN, store 1 to 0x0FFC → `done`=1, `status`=1, `cycle_cnt`=10, `fail_code`=0.
- Store 0x0000_0007 to 0x0FFC → `status`=2, `fail_code`=3. A later store to 0x0FFC with value 1 leaves the verdict unchanged.
- No tohost store, TIMEOUT_CYCLES=20 → `status`=3 and `cycle_cnt`=20; the same run with a tohost store on cycle 20 → `status`=1.
- Macro on, `pc` held at 0x40 with `instr`=0x0000006F for 4 cycles → PASS. With the macro off, the same stimulus → TIMEOUT.
- `restart` pulse in DONE → next edge `done`=0, `cpu_rst_n`=0, `cycle_cnt`=0. `rst_n` low mid-RUN → outputs at reset values asynchronously.
